// File: rtl/wavetable_loader.sv
// Wavetable loader: streams samples into the AWG table RAM at incrementing addresses.
// Optional running checksum enabled by defining WTL_CHECKSUM_EN.
module wavetable_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   range,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_inc;
  logic                len_ok;
  logic                accept;
  logic                illegal;
  logic                xfer;
  logic                aborted;

  assign cnt_inc = cnt + ONE;
  assign len_ok  = (length != '0) && (length <= DEPTH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    illegal   = 1'b0;
    xfer      = 1'b0;
    aborted   = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        // abort takes priority over a sample offered in the same cycle
        if (abort) begin
          aborted   = 1'b1;
          state_nxt = IDLE;
        end else if (s_valid) begin
          xfer = 1'b1;
          if (cnt_inc == len_q) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      error   <= 1'b0;
      range   <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= cnt[ADDR_WIDTH-1:0];
        wr_data <= s_data;
        cnt     <= cnt_inc;
      end
      if (accept) begin
        len_q <= length;
        cnt   <= '0;
        error <= 1'b0;
      end
      if (illegal || aborted) error <= 1'b1;
      if (state == DONE) range <= len_q;
    end
  end

`ifdef WTL_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset || accept) sum_q <= '0;
    else if (wr_en)      sum_q <= sum_q + wr_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_wavetable_loader.sv
// Self-checking bench for wavetable_loader: randomized stream against a transaction-level model.
module tb_wavetable_loader;

  localparam int DW = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   range;
  logic [DW-1:0] checksum;

  wavetable_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .range(range), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;

  // Reference model: a load is "active" until len samples are accepted,
  // followed by a single completion cycle.
  bit m_active, m_fin, m_wr, m_err;
  int m_n, m_len, m_addr, m_data, m_range, m_sum;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int  nsum;
    bit  nwr;
    int  exp_ck;
    if (reset) begin
      m_active = 0; m_fin = 0; m_wr = 0; m_err = 0;
      m_n = 0; m_len = 0; m_addr = 0; m_data = 0; m_range = 0; m_sum = 0;
    end else begin
      nsum = m_wr ? (m_sum + m_data) % 65536 : m_sum;
      nwr  = 0;
      if (m_fin) begin
        m_fin   = 0;
        m_range = m_len;
      end else if (m_active) begin
        if (abort) begin
          m_active = 0;
          m_err    = 1;
        end else if (s_valid) begin
          nwr    = 1;
          m_addr = m_n;
          m_data = int'(s_data);
          m_n++;
          if (m_n == m_len) begin
            m_active = 0;
            m_fin    = 1;
          end
        end
      end else if (start) begin
        if (length >= 1 && length <= 2048) begin
          m_active = 1; m_len = int'(length); m_n = 0; m_err = 0; nsum = 0;
        end else begin
          m_err = 1;
        end
      end
      m_wr  = nwr;
      m_sum = nsum;
    end
    @(posedge clk);
    #1;
    if (wr_en) wr_cnt++;
`ifdef WTL_CHECKSUM_EN
    exp_ck = m_sum;
`else
    exp_ck = 0;
`endif
    check("wr_en", wr_en, m_wr);
    if (m_wr || reset) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
    end
    check("s_ready", s_ready, m_active);
    check("busy", busy, m_active | m_fin);
    check("done", done, m_fin);
    check("error", error, m_err);
    check("range", range, m_range);
    check("checksum", checksum, exp_ck);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      abort   = 1'b0;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      step();
    end
  endtask

  task automatic begin_load(input int len);
    start   = 1'b1;
    length  = (AW+1)'(len);
    s_valid = 1'b0;
    step();
    start   = 1'b0;
  endtask

  initial begin
    int w0;
    int budget;

    // Reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle_steps(3);

    // Test 1: length 4, continuous valid
    begin_load(4);
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = DW'((i + 1) * 16'h1111);
      step();
    end
    check("t1_done_with_last", {31'd0, done}, 1);
    check("t1_last_addr", wr_addr, 3);
    idle_steps(2);
    check("t1_writes", wr_cnt - w0, 4);
    check("t1_range", range, 4);

    // Test 4: length 8, abort together with valid after 3 samples
    begin_load(8);
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      step();
    end
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = DW'($urandom);
    step();
    abort = 1'b0;
    idle_steps(3);
    check("t4_writes", wr_cnt - w0, 3);
    check("t4_error", error, 1);
    check("t4_range", range, 4);

    // Test 3: illegal lengths
    w0 = wr_cnt;
    begin_load(0);
    check("t3_err_len0", error, 1);
    idle_steps(2);
    begin_load(2049);
    check("t3_err_len2049", error, 1);
    idle_steps(2);
    begin_load(4095);
    idle_steps(2);
    check("t3_writes", wr_cnt - w0, 0);

    // Test 5: reset in the middle of a 16-sample load
    begin_load(16);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      step();
    end
    reset   = 1'b1;
    s_valid = 1'b1;
    step();
    reset = 1'b0;
    check("t5_range_rst", range, 0);
    check("t5_err_rst", error, 0);
    idle_steps(2);
    begin_load(5);
    w0 = wr_cnt;
    budget = 0;
    while ((m_active || m_fin) && budget < 200) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      step();
      budget++;
    end
    check("t5_timeout", budget < 200, 1);
    idle_steps(1);
    check("t5_writes", wr_cnt - w0, 5);
    check("t5_range", range, 5);

    // Test 6: checksum wraps modulo 2**16
    begin_load(2);
    s_valid = 1'b1; s_data = 16'hFFFF; step();
    s_valid = 1'b1; s_data = 16'h0002; step();
    s_valid = 1'b0;
    step();
`ifdef WTL_CHECKSUM_EN
    check("t6_checksum", checksum, 1);
`else
    check("t6_checksum", checksum, 0);
`endif
    idle_steps(2);

    // Test 2: full depth with random valid gaps
    begin_load(2048);
    w0 = wr_cnt;
    budget = 0;
    while ((m_active || m_fin) && budget < 20000) begin
      s_valid = 1'($urandom_range(0, 2) != 0);
      s_data  = DW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        start  = 1'b1;
        length = (AW+1)'($urandom_range(1, 100));
      end else begin
        start = 1'b0;
      end
      step();
      budget++;
    end
    start = 1'b0;
    check("t2_timeout", budget < 20000, 1);
    idle_steps(4);
    check("t2_writes", wr_cnt - w0, 2048);
    check("t2_range", range, 2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
